weight_load_sched: RTL and testbench

- Controller between the host weight stream and NUM_PE per-PE weight buffers.
- Captures one kernel (kernel_size words) from a valid/ready stream into a local staging RAM.
- Replays the kernel into each PE buffer in turn, gap-free, via a one-cycle flush pulse followed by one word per cycle.
- Then issues read-enable passes to all PEs and reports done.

---
 rtl/weight_pkg.sv | 24 ++
 rtl/weight_stage_ram.sv | 26 ++
 rtl/weight_load_sched.sv | 164 ++++++++++++++++
 tb/tb_weight_load_sched.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared definitions for the weight load scheduler: default sizes, FSM state
// encoding and the kernel-size legality check.
// Latency: n/a (definitions only). Backpressure: n/a.
package weight_pkg;

  localparam int W_DATA_WIDTH = 16;
  localparam int W_MAX_K      = 16;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CAPTURE = 4'd1;
  localparam logic [3:0] ST_SEL     = 4'd2;
  localparam logic [3:0] ST_FLUSH   = 4'd3;
  localparam logic [3:0] ST_REPLAY  = 4'd4;
  localparam logic [3:0] ST_WAITW   = 4'd5;
  localparam logic [3:0] ST_RUN     = 4'd6;
  localparam logic [3:0] ST_RDWAIT  = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  // A kernel must hold at least one word and fit in the staging RAM.
  function automatic logic kernel_legal(input logic [7:0] k, input int max_k);
    return (k != 8'd0) && (int'(k) <= max_k);
  endfunction

endpackage

// File: rtl/weight_stage_ram.sv
// Staging RAM holding one captured kernel: MAX_K x DATA_WIDTH, 1W/1R.
// Latency: write lands on the next clk edge; read is combinational.
// Backpressure: none; ports: we/waddr/wdata write side, raddr/rdata read side.
module weight_stage_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_K      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are fully rewritten by every capture before replay, so no reset.
  logic [DATA_WIDTH-1:0] mem [MAX_K];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/weight_load_sched.sv
// Captures one kernel from a valid/ready stream, replays it into each
// unconfigured PE buffer (flush pulse + one word/cycle), then runs read passes.
// Latency: data reaches a PE 1 cycle after its flush; s_ready only in CAPTURE,
// WAITW stalls on wb_busy, RDWAIT stalls on wb_rd_valid rise and fall.
// Ports: start/kernel_size/n_passes command; s_* weight stream; wb_* PE buffer
// side; busy/done/skipped/err status.
module weight_load_sched
  import weight_pkg::*;
#(
  parameter int DATA_WIDTH = W_DATA_WIDTH,
  parameter int NUM_PE     = 4,
  parameter int MAX_K      = W_MAX_K,
  parameter int PASS_W     = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [7:0]            kernel_size,
  input  logic [PASS_W-1:0]     n_passes,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [NUM_PE-1:0]     wb_flush,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic [NUM_PE-1:0]     wb_busy,
  input  logic [NUM_PE-1:0]     wb_uncfg,
  output logic                  wb_en,
  input  logic [NUM_PE-1:0]     wb_rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_PE-1:0]     skipped,
  output logic                  err
);

  // One extra counter bit so a count of MAX_K is representable.
  localparam int CW = $clog2(MAX_K) + 1;
  localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [3:0]            state;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         k_q;
  logic [PASS_W-1:0]     p_q;
  logic [PW-1:0]         pe;
  logic                  rd_seen;
  logic [DATA_WIDTH-1:0] stage_rdata;
  logic                  accept;
  logic                  last_word;
  logic                  last_pe;
  logic [3:0]            after_load;

  assign accept     = (state == ST_CAPTURE) && s_valid;
  assign last_word  = (cnt == k_q - CW'(1));
  assign last_pe    = (pe == PW'(NUM_PE - 1));
  assign after_load = (p_q != '0) ? ST_RUN : ST_DONE;

  // cnt is the capture write pointer and, after FLUSH clears it, the replay
  // read pointer.
  weight_stage_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_K      (MAX_K),
    .AW         (AW)
  ) u_stage (
    .clk   (clk),
    .we    (accept),
    .waddr (cnt[AW-1:0]),
    .wdata (s_data),
    .raddr (cnt[AW-1:0]),
    .rdata (stage_rdata)
  );

  // All strobes decode straight from state so a reset silences them at once.
  assign s_ready  = (state == ST_CAPTURE);
  assign wb_flush = (state == ST_FLUSH) ? (NUM_PE'(1) << pe) : '0;
  assign wb_data  = (state == ST_REPLAY) ? stage_rdata : '0;
  assign wb_en    = (state == ST_RUN);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      k_q     <= '0;
      p_q     <= '0;
      pe      <= '0;
      rd_seen <= 1'b0;
      skipped <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_q     <= kernel_size[CW-1:0];
            p_q     <= n_passes;
            cnt     <= '0;
            pe      <= '0;
            skipped <= '0;
            if (kernel_legal(kernel_size, MAX_K)) begin
              err   <= 1'b0;
              state <= ST_CAPTURE;
            end else begin
              err   <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_CAPTURE: begin
          if (s_valid) begin
            cnt <= cnt + CW'(1);
            if (last_word) begin
              pe    <= '0;
              state <= ST_SEL;
            end
          end
        end
        ST_SEL: begin
          // An already-configured PE keeps its old kernel and is skipped.
          if (!wb_uncfg[pe]) begin
            skipped[pe] <= 1'b1;
            if (last_pe) state <= after_load;
            else         pe    <= pe + PW'(1);
          end else begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          cnt   <= '0;
          state <= ST_REPLAY;
        end
        ST_REPLAY: begin
          if (last_word) state <= ST_WAITW;
          else           cnt   <= cnt + CW'(1);
        end
        ST_WAITW: begin
          if (!wb_busy[pe]) begin
            if (last_pe) begin
              state <= after_load;
            end else begin
              pe    <= pe + PW'(1);
              state <= ST_SEL;
            end
          end
        end
        ST_RUN: begin
          rd_seen <= 1'b0;
          state   <= ST_RDWAIT;
        end
        ST_RDWAIT: begin
          // A pass ends only after every PE has started and then finished.
          if (!rd_seen) begin
            if (&wb_rd_valid) rd_seen <= 1'b1;
          end else if (~|wb_rd_valid) begin
            p_q   <= p_q - PASS_W'(1);
            state <= (p_q > PASS_W'(1)) ? ST_RUN : ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_load_sched.sv
// Bench for weight_load_sched: directed scenarios with random data/valid/uncfg,
// PE buffer busy and read-valid behaviour modelled in the bench.
// Latency/backpressure: exercised via stalled streams and wb_busy/wb_rd_valid.
module tb_weight_load_sched;

  localparam int DW  = 16;
  localparam int NPE = 4;
  localparam int MK  = 16;
  localparam int PW  = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           start = 1'b0;
  logic [7:0]     kernel_size = '0;
  logic [PW-1:0]  n_passes = '0;
  logic [DW-1:0]  s_data = '0;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [NPE-1:0] wb_flush;
  logic [DW-1:0]  wb_data;
  logic [NPE-1:0] wb_busy = '0;
  logic [NPE-1:0] wb_uncfg = '1;
  logic           wb_en;
  logic [NPE-1:0] wb_rd_valid = '0;
  logic           busy;
  logic           done;
  logic [NPE-1:0] skipped;
  logic           err;

  weight_load_sched #(.DATA_WIDTH(DW), .NUM_PE(NPE), .MAX_K(MK), .PASS_W(PW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .kernel_size(kernel_size),
    .n_passes(n_passes), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wb_flush(wb_flush), .wb_data(wb_data), .wb_busy(wb_busy), .wb_uncfg(wb_uncfg),
    .wb_en(wb_en), .wb_rd_valid(wb_rd_valid), .busy(busy), .done(done),
    .skipped(skipped), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Observation logs, refilled for every run.
  logic [NPE-1:0] flush_q[$];
  int             flush_cyc[$];
  int             en_cyc[$];
  int             fall_cyc[$];
  int             done_cyc[$];
  logic [DW-1:0]  acc_q[$];
  logic [DW-1:0]  data_at[int];
  bit             inwin[int];
  int             en_early = 0;
  int             srdy_cnt = 0;
  logic [NPE-1:0] prev_rv = '0;

  logic [DW-1:0]  words[$];
  int             start_c = 0;
  int             cur_k = 1;
  int             bc[NPE];
  int             rc[NPE];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    data_at[cyc] = wb_data;
    if (wb_flush != '0) begin flush_q.push_back(wb_flush); flush_cyc.push_back(cyc); end
    if (wb_en) begin en_cyc.push_back(cyc); if (wb_rd_valid != '0) en_early++; end
    if (prev_rv != '0 && wb_rd_valid == '0) fall_cyc.push_back(cyc);
    prev_rv = wb_rd_valid;
    if (done) done_cyc.push_back(cyc);
    if (s_valid && s_ready) acc_q.push_back(s_data);
    if (s_ready) srdy_cnt++;
  end

  // PE buffer model: busy from the cycle after flush until a little after its
  // last word; read-valid high for K+1 (+0..2, per PE) cycles after wb_en.
  initial begin
    for (int i = 0; i < NPE; i++) begin bc[i] = 0; rc[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NPE; i++) begin
        if (!rstn) begin
          bc[i] = 0; rc[i] = 0;
        end else begin
          if (wb_flush[i]) bc[i] = cur_k + 1 + int'($urandom_range(0, 3));
          else if (bc[i] > 0) bc[i]--;
          if (wb_en) rc[i] = cur_k + 1 + int'($urandom_range(0, 2));
          else if (rc[i] > 0) rc[i]--;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NPE; i++) begin
        wb_busy[i]     = (bc[i] > 0);
        wb_rd_valid[i] = (rc[i] > 0);
      end
    end
  end

  task automatic clear_logs();
    flush_q.delete(); flush_cyc.delete(); en_cyc.delete(); fall_cyc.delete();
    done_cyc.delete(); acc_q.delete(); data_at.delete(); inwin.delete();
    en_early = 0; srdy_cnt = 0;
  endtask

  // mode 0: gap-free 1..K, mode 1: valid pattern 1,0,0,1,1,0,1, else random.
  task automatic start_run(input int k, input int p, input logic [NPE-1:0] uncfg, input int mode);
    bit [6:0] pat;
    int idx, pi, guard;
    bit v;
    pat = 7'b1011001;
    @(posedge clk); #1;
    clear_logs();
    cur_k = k;
    wb_uncfg = uncfg;
    words.delete();
    for (int i = 0; i < k; i++) words.push_back(mode == 0 ? DW'(i + 1) : DW'($urandom));
    start = 1'b1; kernel_size = 8'(k); n_passes = PW'(p); start_c = cyc;
    @(posedge clk); #1;
    start = 1'b0; kernel_size = 8'($urandom); n_passes = PW'($urandom);
    if (k >= 1 && k <= MK) begin
      idx = 0; pi = 0; guard = 0;
      while (idx < k && guard < 400) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = pat[pi % 7];
          default: v = 1'($urandom_range(0, 1));
        endcase
        s_valid = v;
        s_data  = words[idx];
        @(negedge clk);
        if (s_valid && s_ready) idx++;
        pi++; guard++;
        @(posedge clk); #1;
      end
      chk("stream_words", idx, k);
      s_valid = 1'b1; s_data = DW'($urandom);
      @(negedge clk);
      chk("srdy_after_last", s_ready, 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
    end else begin
      s_valid = 1'b1; s_data = DW'($urandom);
      @(negedge clk);
      chk("illegal_done_next", done, 1);
      chk("illegal_err", err, 1);
      chk("illegal_srdy", s_ready, 0);
      @(posedge clk); #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic finish_run(input int k, input int p, input logic [NPE-1:0] uncfg, input bit poke);
    bit legal, got;
    logic [NPE-1:0] exp_skip;
    int exp_pe[$];
    int nz, t;
    legal = (k >= 1 && k <= MK);
    exp_skip = legal ? ~uncfg : '0;
    got = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(posedge clk); #1;
      start = poke && (i == 5);
      if (start) kernel_size = 8'd3;
      @(negedge clk);
      if (done || done_cyc.size() > 0) got = 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_seen", got, 1);
    repeat (4) @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_once", done_cyc.size(), 1);
    chk("err_flag", err, !legal);
    chk("skipped", skipped, exp_skip);
    if (!legal) begin
      chk("illegal_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, start_c + 1);
      chk("illegal_no_flush", flush_q.size(), 0);
      chk("illegal_no_srdy", srdy_cnt, 0);
      chk("illegal_no_en", en_cyc.size(), 0);
    end else begin
      chk("acc_cnt", acc_q.size(), k);
      for (int i = 0; i < acc_q.size() && i < k; i++) chk("acc_word", acc_q[i], words[i]);
      for (int i = 0; i < NPE; i++) if (uncfg[i]) exp_pe.push_back(i);
      chk("flush_cnt", flush_q.size(), exp_pe.size());
      for (int n = 0; n < flush_q.size() && n < exp_pe.size(); n++) begin
        chk("flush_pe", flush_q[n], 1 << exp_pe[n]);
        t = flush_cyc[n];
        for (int j = 0; j < k; j++) begin
          inwin[t + 1 + j] = 1'b1;
          chk("replay_word", data_at.exists(t + 1 + j) ? data_at[t + 1 + j] : 'x, words[j]);
        end
      end
      nz = 0;
      for (int c = start_c; c <= cyc; c++)
        if (!inwin.exists(c) && data_at.exists(c) && data_at[c] != '0) nz++;
      chk("data_idle_zero", nz, 0);
      chk("en_cnt", en_cyc.size(), p);
      chk("en_while_rd", en_early, 0);
      chk("fall_cnt", fall_cyc.size(), p);
      for (int i = 1; i < en_cyc.size() && i <= fall_cyc.size(); i++)
        chk("en_after_fall", en_cyc[i], fall_cyc[i - 1] + 1);
      if (p > 0 && fall_cyc.size() == p && done_cyc.size() > 0)
        chk("done_after_fall", done_cyc[0], fall_cyc[p - 1] + 1);
    end
  endtask

  initial begin
    int fsz;
    int rk, rp;
    logic [NPE-1:0] ru;
    #2;
    chk("rst_srdy", s_ready, 0);
    chk("rst_flush", wb_flush, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_en", wb_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_skipped", skipped, 0);
    chk("rst_err", err, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Normal load, stalled stream, pre-configured PE, read passes.
    start_run(9, 0, 4'hF, 0);     finish_run(9, 0, 4'hF, 1'b1);
    start_run(4, 0, 4'hF, 1);     finish_run(4, 0, 4'hF, 1'b0);
    start_run(5, 0, 4'b1011, 2);  finish_run(5, 0, 4'b1011, 1'b0);
    start_run(6, 3, 4'hF, 2);     finish_run(6, 3, 4'hF, 1'b1);

    // Illegal sizes.
    start_run(0, 1, 4'hF, 0);     finish_run(0, 1, 4'hF, 1'b0);
    start_run(17, 0, 4'hF, 0);    finish_run(17, 0, 4'hF, 1'b0);

    // Reset in the middle of PE1's replay.
    start_run(8, 0, 4'hF, 0);
    for (int i = 0; i < 300 && flush_q.size() < 2; i++) @(negedge clk);
    chk("reached_replay", flush_q.size() >= 2, 1);
    @(posedge clk); #2;
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_flush", wb_flush, 0);
    chk("midrst_data", wb_data, 0);
    chk("midrst_en", wb_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_srdy", s_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_skipped", skipped, 0);
    fsz = flush_q.size();
    repeat (3) @(negedge clk);
    chk("rst_no_more_flush", flush_q.size(), fsz);
    @(posedge clk); #2;
    rstn = 1'b1;
    start_run(MK, 2, 4'(($urandom_range(0, 14)) | 1), 2);
    finish_run(MK, 2, wb_uncfg, 1'b0);

    // Random runs.
    for (int r = 0; r < 4; r++) begin
      rk = int'($urandom_range(1, MK));
      rp = int'($urandom_range(0, 3));
      ru = 4'($urandom);
      start_run(rk, rp, ru, 2);
      finish_run(rk, rp, ru, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
